// File: rtl/voice_allocator_if.sv
// Event and voice-status bundle for voice_allocator.
// master: key event source; slave: allocator (ready, voices, pulses).
interface voice_allocator_if #(
    parameter int VOICES = 4
);
    logic [2:0]          key_num_i;
    logic                key_on_i;
    logic                key_off_i;
    logic                ready_o;
    logic [VOICES-1:0]   voice_en_o;
    logic [3*VOICES-1:0] voice_note_o;
    logic [VOICES-1:0]   voice_start_o;
    logic                drop_o;

    modport master (
        output key_num_i, key_on_i, key_off_i,
        input  ready_o, voice_en_o, voice_note_o,
        input  voice_start_o, drop_o
    );

    modport slave (
        input  key_num_i, key_on_i, key_off_i,
        output ready_o, voice_en_o, voice_note_o,
        output voice_start_o, drop_o
    );
endinterface

// File: rtl/voice_allocator.sv
// Shares VOICES tone voices among 8 keys with a serial voice scan.
// Ports: clk_i, rst_i (async, active-high), bus (voice_allocator_if.slave):
//   key_num_i/key_on_i/key_off_i events in, ready_o, voice_en_o,
//   voice_note_o (3 bits per voice), voice_start_o and drop_o pulses out.
// Option: define VOICE_ALLOCATOR_STEAL_EN to steal the oldest voice when
//   all are busy; otherwise such a press is dropped with a drop_o pulse.
module voice_allocator #(
    parameter int VOICES = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    voice_allocator_if.slave bus
);
    localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_COMMIT
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        ev_key;
    logic              ev_off;
    logic [IW-1:0]     idx_q;
    logic              m_found, f_found, o_found;
    logic [IW-1:0]     m_idx, f_idx, o_idx;
    logic [7:0]        o_age;

    logic [VOICES-1:0] en_q;
    logic [2:0]        note_q [VOICES];
    logic [7:0]        age_q  [VOICES];
    logic [VOICES-1:0] start_q;
    logic              drop_q;

    logic              accept;
    logic              do_assign, do_clear, do_drop;
    logic [IW-1:0]     tgt;

    assign accept = (state_q == S_IDLE) &&
                    (bus.key_on_i || bus.key_off_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state plus the commit decision taken from the scan results.
    always_comb begin
        state_d   = state_q;
        do_assign = 1'b0;
        do_clear  = 1'b0;
        do_drop   = 1'b0;
        tgt       = '0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (idx_q == LAST) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                if (ev_off) begin
                    do_clear = m_found;
                    tgt      = m_idx;
                end else if (!m_found) begin
                    if (f_found) begin
                        do_assign = 1'b1;
                        tgt       = f_idx;
                    end else begin
                        tgt = o_idx;
`ifdef VOICE_ALLOCATOR_STEAL_EN
                        do_assign = 1'b1;
`else
                        do_drop = 1'b1;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ev_key  <= '0;
            ev_off  <= 1'b0;
            idx_q   <= '0;
            m_found <= 1'b0;
            f_found <= 1'b0;
            o_found <= 1'b0;
            m_idx   <= '0;
            f_idx   <= '0;
            o_idx   <= '0;
            o_age   <= '0;
            en_q    <= '0;
            start_q <= '0;
            drop_q  <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                note_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            start_q <= '0;
            drop_q  <= do_drop;

            if (accept) begin
                ev_key  <= bus.key_num_i;
                ev_off  <= bus.key_off_i;
                idx_q   <= '0;
                m_found <= 1'b0;
                f_found <= 1'b0;
                o_found <= 1'b0;
                m_idx   <= '0;
                f_idx   <= '0;
                o_idx   <= '0;
                o_age   <= '0;
            end

            if (state_q == S_SCAN) begin
                idx_q <= idx_q + 1'b1;
                if (en_q[idx_q] && note_q[idx_q] == ev_key) begin
                    m_found <= 1'b1;
                    m_idx   <= idx_q;
                end
                if (!en_q[idx_q] && !f_found) begin
                    f_found <= 1'b1;
                    f_idx   <= idx_q;
                end
                // Strictly greater keeps the lowest index on age ties.
                if (en_q[idx_q] && (!o_found || age_q[idx_q] > o_age)) begin
                    o_found <= 1'b1;
                    o_idx   <= idx_q;
                    o_age   <= age_q[idx_q];
                end
            end

            if (do_clear) en_q[tgt] <= 1'b0;

            if (do_assign) begin
                for (int i = 0; i < VOICES; i++) begin
                    if (IW'(i) == tgt) begin
                        en_q[i]    <= 1'b1;
                        note_q[i]  <= ev_key;
                        age_q[i]   <= '0;
                        start_q[i] <= 1'b1;
                    end else if (en_q[i] && age_q[i] != 8'hff) begin
                        age_q[i] <= age_q[i] + 8'd1;
                    end
                end
            end
        end
    end

    assign bus.ready_o       = (state_q == S_IDLE);
    assign bus.voice_en_o    = en_q;
    assign bus.voice_start_o = start_q;
    assign bus.drop_o        = drop_q;

    for (genvar g = 0; g < VOICES; g++) begin : g_note
        assign bus.voice_note_o[3*g +: 3] = note_q[g];
    end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter VOICES, default 4, number of tone-generator voices shared among the 8 keys; legal range 2..8.
REQ-002 SHALL have port clk_i  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port key_num_i  input  3  key index 0..7 from the PS/2 decoder.
REQ-005 SHALL have port key_on_i  input  1  single-cycle key-press event for key_num_i.
REQ-006 SHALL have port key_off_i  input  1  single-cycle key-release event for key_num_i.
REQ-007 SHALL have port ready_o  output  1  high when an event can be accepted.
REQ-008 SHALL have port voice_en_o  output  VOICES  per-voice busy/sounding flag.
REQ-009 SHALL have port voice_note_o  output  3*VOICES  per-voice key index; voice v occupies bits [3v+2:3v].
REQ-010 SHALL have port voice_start_o  output  VOICES  one-cycle pulse when a voice is (re)assigned a note.
REQ-011 SHALL have port drop_o  output  1  one-cycle pulse when a key-on cannot be allocated.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN, COMMIT; ready_o = 1 only in IDLE.
REQ-013 In IDLE with key_off_i = 1, SHALL capture key_num_i as a release event and go to SCAN; key_off_i has priority, so a simultaneous key_on_i is discarded with no drop_o.
REQ-014 In IDLE with key_on_i = 1 and key_off_i = 0, SHALL capture a press event and go to SCAN.
REQ-015 Events arriving outside IDLE SHALL be ignored, with no state change and no drop_o.
REQ-016 SCAN SHALL examine one voice per cycle, index 0 to VOICES-1, for exactly VOICES cycles, recording: the matching busy voice (same note), the lowest-index free voice, and the oldest busy voice; then go to COMMIT.
REQ-017 COMMIT SHALL last one cycle, apply the decision, and return to IDLE; for an event accepted in cycle T, outputs update at the edge ending cycle T+VOICES+1, and ready_o is high again in cycle T+VOICES+2.
REQ-018 Release: if a matching busy voice exists, SHALL clear its voice_en_o bit while keeping voice_note_o; otherwise no change.
REQ-019 Press with a matching busy voice SHALL cause no change: no start pulse and no drop.
REQ-020 Press with no matching voice and a free voice SHALL assign the lowest-index free voice: set en, load note, clear its age, and pulse voice_start_o[v] in the cycle after COMMIT.
REQ-021 Press with no match and all voices busy SHALL follow REQ-030/031.
REQ-022 Each voice SHALL hold an 8-bit age, incremented by 1 (saturating at 255) for every busy voice not assigned on each committed press.
REQ-023 Oldest SHALL mean the greatest age; ties SHALL resolve to the lowest index.
REQ-024 drop_o and voice_start_o SHALL be registered single-cycle pulses, never asserted in the same cycle.

Reset
REQ-025 While rst_i = 1, the FSM SHALL be in IDLE with ready_o = 1.
REQ-026 While rst_i = 1, voice_en_o, voice_note_o, voice_start_o, drop_o, all ages and all captured event state SHALL be 0.
REQ-027 Reset asserted during SCAN or COMMIT SHALL abort the event with no partial update.

Configuration
REQ-028 SHALL support macro VOICE_ALLOCATOR_STEAL_EN.
REQ-029 The macro SHALL affect only the all-voices-busy press case.
REQ-030 With VOICE_ALLOCATOR_STEAL_EN defined, a press with all voices busy SHALL reassign the oldest voice: load the note, reset its age, pulse voice_start_o, no drop_o.
REQ-031 Without VOICE_ALLOCATOR_STEAL_EN, a press with all voices busy SHALL change no voice state and SHALL pulse drop_o one cycle after COMMIT.

Verification
REQ-032 Reset, then key_on key 2 -> voice_en_o = 0001, voice 0 note = 2, voice_start_o = 0001 one pulse, ready_o low for exactly VOICES+1 cycles.
REQ-033 Press keys 0,1,2,3, then key_off key 1 -> voice_en_o = 1101; next press key 5 -> voice 1 note = 5, voice_en_o = 1111.
REQ-034 With 4 voices busy (keys 0,1,2,3 in order), press key 7 -> STEAL_EN: voice 0 note = 7, start pulse 0001; without the macro: drop_o pulse, voices unchanged.
REQ-035 key_on and key_off both high for key 4 while voice holds 4 -> release only, voice_en bit cleared, no start, no drop.
REQ-036 Press key 6 twice -> second press causes no output change; an event while ready_o = 0 is ignored.
REQ-037 rst_i pulsed mid-SCAN -> all outputs 0 immediately, ready_o = 1.
